// File: rtl/tilemap_write_scheduler.sv
// Tilemap port-B write scheduler: arbitrates single-tile writes from game logic
// and the CPU, packs 8-bit tile IDs into 32-bit words via byte enables, and
// runs a whole-map fill engine that takes over the port once the pipeline drains.
module tilemap_write_scheduler #(
    parameter int MAP_WIDTH  = 40,
    parameter int MAP_HEIGHT = 30,
    parameter int MAP_WORDS  = MAP_WIDTH * MAP_HEIGHT / 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ga_valid,
    output logic        ga_ready,
    input  logic [5:0]  ga_x,
    input  logic [4:0]  ga_y,
    input  logic [7:0]  ga_tile,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [5:0]  cpu_x,
    input  logic [4:0]  cpu_y,
    input  logic [7:0]  cpu_tile,
    input  logic        fill_start,
    input  logic [7:0]  fill_tile,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        oob_err,
    output logic        bram_en,
    output logic [3:0]  bram_we,
    output logic [10:0] bram_addr,
    output logic [31:0] bram_din
);

    localparam int CNT_W = $clog2(MAP_WORDS + 1);

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t             state_q;
    logic               ptr_q;          // 0: game logic has priority, 1: CPU
    logic [CNT_W-1:0]   cnt_q;
    logic [7:0]         fill_tile_q;
    logic               fill_busy_q;
    logic               fill_done_q;
    logic               oob_err_q;
    logic               bram_en_q;
    logic [3:0]         bram_we_q;
    logic [10:0]        bram_addr_q;
    logic [31:0]        bram_din_q;

    logic               s1_vld_q;
    logic [5:0]         s1_x_q;
    logic [4:0]         s1_y_q;
    logic [7:0]         s1_tile_q;
    logic               s2_vld_q;
    logic [10:0]        s2_idx_q;
    logic               s2_oob_q;
    logic [7:0]         s2_tile_q;

    logic               idle;
    logic               grant_ga;
    logic               grant_cpu;
    logic               accept;
    logic [5:0]         sel_x_d;
    logic [4:0]         sel_y_d;
    logic [7:0]         sel_tile_d;
    logic [10:0]        idx_d;
    logic               oob_d;

    // Fill requests pre-empt same-cycle single requests; contention follows the pointer.
    assign idle       = (state_q == S_IDLE);
    assign grant_ga   = ga_valid && (!cpu_valid || !ptr_q);
    assign grant_cpu  = cpu_valid && (!ga_valid || ptr_q);
    assign ga_ready   = idle && !fill_start && grant_ga;
    assign cpu_ready  = idle && !fill_start && grant_cpu;
    assign accept     = ga_ready || cpu_ready;

    assign sel_x_d    = ga_ready ? ga_x : cpu_x;
    assign sel_y_d    = ga_ready ? ga_y : cpu_y;
    assign sel_tile_d = ga_ready ? ga_tile : cpu_tile;

    // Index wraps harmlessly for out-of-range coordinates; the oob flag suppresses the write.
    assign idx_d = 11'(s1_y_q) * 11'(MAP_WIDTH) + 11'(s1_x_q);
    assign oob_d = (s1_x_q >= 6'(MAP_WIDTH)) || (s1_y_q >= 5'(MAP_HEIGHT));

    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;
    assign oob_err   = oob_err_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = bram_din_q;

    // Pipeline payload registers; contents are meaningless unless the matching valid is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_x_q    <= sel_x_d;
            s1_y_q    <= sel_y_d;
            s1_tile_q <= sel_tile_d;
        end
        s2_idx_q  <= idx_d;
        s2_oob_q  <= oob_d;
        s2_tile_q <= s1_tile_q;
        if (idle && fill_start) begin
            fill_tile_q <= fill_tile;
        end
    end

    // Control FSM, pipeline valids, arbiter pointer and registered port-B outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            cnt_q       <= '0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
            oob_err_q   <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'h0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
        end else begin
            bram_en_q   <= 1'b0;
            bram_we_q   <= 4'h0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            oob_err_q   <= 1'b0;
            fill_done_q <= 1'b0;

            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
            if (accept) begin
                ptr_q <= ga_ready;
            end

            if (s2_vld_q) begin
                if (s2_oob_q) begin
                    oob_err_q <= 1'b1;
                end else begin
                    bram_en_q   <= 1'b1;
                    bram_we_q   <= 4'b0001 << s2_idx_q[1:0];
                    bram_addr_q <= {2'b00, s2_idx_q[10:2]};
                    bram_din_q  <= {4{s2_tile_q}};
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (fill_start) begin
                        state_q <= S_FILL;
                        cnt_q   <= '0;
                    end
                end
                S_FILL: begin
                    // The first FILL cycle only raises busy; that gap lets the last
                    // single write leave the pipeline before word 0 is issued.
                    if (fill_busy_q && (cnt_q == CNT_W'(MAP_WORDS))) begin
                        state_q     <= S_IDLE;
                        fill_busy_q <= 1'b0;
                        fill_done_q <= 1'b1;
                    end else begin
                        fill_busy_q <= 1'b1;
                        if (fill_busy_q) begin
                            bram_en_q   <= 1'b1;
                            bram_we_q   <= 4'hF;
                            bram_addr_q <= 11'(cnt_q);
                            bram_din_q  <= {4{fill_tile_q}};
                            cnt_q       <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tilemap_write_scheduler.sv
// Scoreboard bench for tilemap_write_scheduler: a reference model predicts
// ready/grant, every port-B write, oob pulse and fill_done with its cycle.
module tb_tilemap_write_scheduler;

    localparam int MW = 40;
    localparam int MH = 30;
    localparam int WORDS = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ga_valid = 1'b0, cpu_valid = 1'b0, fill_start = 1'b0;
    logic        ga_ready, cpu_ready;
    logic [5:0]  ga_x = '0, cpu_x = '0;
    logic [4:0]  ga_y = '0, cpu_y = '0;
    logic [7:0]  ga_tile = '0, cpu_tile = '0, fill_tile = '0;
    logic        fill_busy, fill_done, oob_err, bram_en;
    logic [3:0]  bram_we;
    logic [10:0] bram_addr;
    logic [31:0] bram_din;

    tilemap_write_scheduler dut (
        .clk(clk), .reset(reset),
        .ga_valid(ga_valid), .ga_ready(ga_ready), .ga_x(ga_x), .ga_y(ga_y), .ga_tile(ga_tile),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_x(cpu_x), .cpu_y(cpu_y),
        .cpu_tile(cpu_tile),
        .fill_start(fill_start), .fill_tile(fill_tile), .fill_busy(fill_busy),
        .fill_done(fill_done), .oob_err(oob_err),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
    );

    always #5 clk = ~clk;

    // kind: 0 = write, 1 = oob pulse, 2 = fill_done pulse
    typedef struct {
        int          kind;
        int          cyc;
        logic [10:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic ptr_m  = 1'b0;
    int fill_lo  = 32'h3fffffff;
    int fill_hi  = 0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    logic last_ga_acc;
    logic last_cpu_acc;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_single(input logic [5:0] x, input logic [4:0] y, input logic [7:0] t,
                               input int e);
        exp_t it;
        int idx;
        idx = int'(y) * MW + int'(x);
        it.cyc = e + 2;
        it.addr = 11'(idx >> 2);
        it.we = 4'b0001 << (idx % 4);
        it.din = {4{t}};
        it.kind = (int'(x) >= MW || int'(y) >= MH) ? 1 : 0;
        exp_q.push_back(it);
    endtask

    // One clock cycle of stimulus; predicts handshakes and queues expected results.
    task automatic step(input logic gv, input logic [5:0] gx, input logic [4:0] gy,
                        input logic [7:0] gt, input logic cv, input logic [5:0] cx,
                        input logic [4:0] cy, input logic [7:0] ct, input logic fs,
                        input logic [7:0] ft);
        logic idle_m, eg, ec;
        int e;
        exp_t it;
        @(posedge clk); #1;
        ga_valid = gv; ga_x = gx; ga_y = gy; ga_tile = gt;
        cpu_valid = cv; cpu_x = cx; cpu_y = cy; cpu_tile = ct;
        fill_start = fs; fill_tile = ft;
        #1;
        e = cyc + 1;
        idle_m = (cyc < fill_lo) || (cyc > fill_hi);
        eg = idle_m && !fs && gv && (!cv || !ptr_m);
        ec = idle_m && !fs && cv && (!gv || ptr_m);
        check_val("ga_ready", {31'b0, ga_ready}, {31'b0, eg});
        check_val("cpu_ready", {31'b0, cpu_ready}, {31'b0, ec});
        last_ga_acc = eg;
        last_cpu_acc = ec;
        if (eg) begin
            push_single(gx, gy, gt, e);
            ptr_m = 1'b1;
        end else if (ec) begin
            push_single(cx, cy, ct, e);
            ptr_m = 1'b0;
        end
        if (idle_m && fs) begin
            fill_lo = e;
            fill_hi = e + WORDS + 1;
            busy_lo = e + 1;
            busy_hi = e + WORDS + 1;
            for (int i = 0; i < WORDS; i++) begin
                it.kind = 0; it.cyc = e + 2 + i; it.addr = 11'(i);
                it.we = 4'hF; it.din = {4{ft}};
                exp_q.push_back(it);
            end
            it.kind = 2; it.cyc = e + WORDS + 2; it.addr = '0; it.we = '0; it.din = '0;
            exp_q.push_back(it);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Output monitor: every port-B event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            check_val("fill_busy", {31'b0, fill_busy},
                      {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
            if (bram_en || oob_err || fill_done) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_event", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("event_kind", fill_done ? 32'd2 : (oob_err ? 32'd1 : 32'd0),
                              mon_e.kind);
                    check_val("event_cycle", cyc, mon_e.cyc);
                    if (mon_e.kind == 0) begin
                        check_val("bram_addr", {21'b0, bram_addr}, {21'b0, mon_e.addr});
                        check_val("bram_we", {28'b0, bram_we}, {28'b0, mon_e.we});
                        check_val("bram_din", bram_din, mon_e.din);
                    end else begin
                        check_val("en_on_nowrite", {31'b0, bram_en}, 32'd0);
                        check_val("we_on_nowrite", {28'b0, bram_we}, 32'd0);
                    end
                end
            end else begin
                check_val("we_idle", {28'b0, bram_we}, 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_en"}, {31'b0, bram_en}, 32'd0);
        check_val({tag, "_we"}, {28'b0, bram_we}, 32'd0);
        check_val({tag, "_addr"}, {21'b0, bram_addr}, 32'd0);
        check_val({tag, "_din"}, bram_din, 32'd0);
        check_val({tag, "_busy"}, {31'b0, fill_busy}, 32'd0);
        check_val({tag, "_done"}, {31'b0, fill_done}, 32'd0);
        check_val({tag, "_oob"}, {31'b0, oob_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int tries;
        int acc_cyc;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset = 1'b1;

        // Single write: (5,2) -> index 85 -> word 21, lane 1
        step(1, 6'd5, 5'd2, 8'h3C, 0, 0, 0, 0, 0, 0);
        idle_steps(4);

        // Bounds (CPU side): two out-of-range, then the far corner
        step(0, 0, 0, 0, 1, 6'd40, 5'd0, 8'h11, 0, 0);
        step(0, 0, 0, 0, 1, 6'd0, 5'd30, 8'h22, 0, 0);
        step(0, 0, 0, 0, 1, 6'd39, 5'd29, 8'h33, 0, 0);
        idle_steps(4);

        // Contention: both valid for four cycles, pointer currently at game logic
        for (int i = 0; i < 4; i++) begin
            step(1, 6'(i), 5'd1, 8'(8'hA0 + i), 1, 6'(i + 10), 5'd3, 8'(8'hB0 + i), 0, 0);
            check_val("contention_grant", {31'b0, ga_ready}, {31'b0, (i % 2 == 0)});
        end
        idle_steps(4);

        // Mixed random traffic including out-of-range coordinates
        for (int i = 0; i < 24; i++) begin
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 45)), 5'($urandom_range(0, 31)),
                 8'($urandom), 1'($urandom_range(0, 1)), 6'($urandom_range(0, 45)),
                 5'($urandom_range(0, 31)), 8'($urandom), 0, 0);
        end
        idle_steps(4);

        // Fill with a single write in flight, and ga_valid held from the fill_start cycle
        step(1, 6'd7, 5'd0, 8'h5A, 0, 0, 0, 0, 0, 0);
        if (!last_ga_acc) step(1, 6'd7, 5'd0, 8'h5A, 0, 0, 0, 0, 0, 0);
        step(1, 6'd3, 5'd1, 8'h55, 0, 0, 0, 0, 1, 8'h07);
        check_val("fill_start_blocks_ga", {31'b0, ga_ready}, 32'd0);
        tries = 0;
        last_ga_acc = 1'b0;
        while (!last_ga_acc && tries < 400) begin
            step(1, 6'd3, 5'd1, 8'h55, 0, 0, 0, 0, (tries == 50), 8'hEE);
            if (last_ga_acc) acc_cyc = cyc;
            tries++;
        end
        check_val("ga_accepted_after_fill", {31'b0, last_ga_acc}, 32'd1);
        check_val("ga_accept_cycle", acc_cyc, fill_lo + WORDS + 2);
        check_val("done_with_accept", {31'b0, fill_done}, 32'd1);
        idle_steps(5);

        // Reset during fill at word 100
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 8'hA5);
        while (cyc < fill_lo + 102) idle_steps(1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1 check_all_zero("midfill_reset");
        exp_q.delete();
        ptr_m = 1'b0;
        fill_lo = 32'h3fffffff; fill_hi = 0; busy_lo = 1; busy_hi = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        idle_steps(6);

        // After reset the pointer favours game logic again
        step(1, 6'd1, 5'd1, 8'hC1, 1, 6'd2, 5'd2, 8'hC2, 0, 0);
        check_val("post_reset_ptr", {31'b0, ga_ready}, 32'd1);
        step(1, 6'd1, 5'd1, 8'hC3, 1, 6'd2, 5'd2, 8'hC4, 0, 0);
        idle_steps(1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        check_val("drain", exp_q.size(), 32'd0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
